// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the instruction-cache address split.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Address split for the default 16-frame instruction cache geometry.
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits,
// a blocking non-abortable fill, and saturating hit/miss counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state, state_next;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr  [SETS];
  word_t            data_arr [SETS];

  word_t            fill_addr;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic             hit, start_fill, fill_done;
  logic             unused_bytoff;

  assign req_tag       = imemaddr[31:2+IDX_W];
  assign req_idx       = imemaddr[IDX_W+1:2];
  assign fill_tag      = fill_addr[31:2+IDX_W];
  assign fill_idx      = fill_addr[IDX_W+1:2];
  assign unused_bytoff = ^{imemaddr[1:0], fill_addr[1:0]};

  assign hit = (state == IDLE) && imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag);

  function automatic word_t sat_inc(input word_t v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_next = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_arr[req_idx];
        end else if (imemREN) begin
          start_fill = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        // Fill runs to the latched address even if fetch redirects meanwhile.
        iREN  = 1'b1;
        iaddr = fill_addr;
        if (!iwait) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      fill_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (start_fill) begin
        fill_addr  <= {imemaddr[31:2], 2'b00};
        miss_count <= sat_inc(miss_count);
      end
      if (hit) hit_count <= sat_inc(hit_count);
      if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage is unreset; the valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

endmodule
